// File: rtl/exu_alu_mc_if.sv
// Execute-stage ALU request/response bundle: operand sources, func and the two handshakes.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready travel against the direction of their valids.
interface exu_alu_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      a_sel;
    logic [1:0]      b_sel;
    logic [3:0]      func;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] imm;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            busy;

    // Issuing side (decode) drives the request and consumes the result.
    modport master (
        output in_valid, a_sel, b_sel, func, src1, src2, pc_out, imm, flush, out_ready,
        input  in_ready, out_valid, alu_result, busy
    );

    // ALU side.
    modport slave (
        input  in_valid, a_sel, b_sel, func, src1, src2, pc_out, imm, flush, out_ready,
        output in_ready, out_valid, alu_result, busy
    );
endinterface

// File: rtl/exu_alu_mc.sv
// Multi-cycle execute ALU: operand select, single-cycle int ops, iterative MUL/MULHU/DIVU/REMU.
// Latency: 1 cycle for single-cycle funcs, XLEN+1 cycles for multiply/divide.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; flush aborts.
module exu_alu_mc #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    exu_alu_mc_if.slave  alu
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;

    localparam logic [3:0] F_ADD    = 4'd1;
    localparam logic [3:0] F_SUB    = 4'd2;
    localparam logic [3:0] F_EQ     = 4'd3;
    localparam logic [3:0] F_NE     = 4'd4;
    localparam logic [3:0] F_LESS_U = 4'd5;
    localparam logic [3:0] F_LESS_S = 4'd6;
    localparam logic [3:0] F_SLL    = 4'd7;
    localparam logic [3:0] F_SRL    = 4'd8;
    localparam logic [3:0] F_SRA    = 4'd9;
    localparam logic [3:0] F_MUL    = 4'd10;
    localparam logic [3:0] F_MULHU  = 4'd11;
    localparam logic [3:0] F_DIVU   = 4'd12;
    localparam logic [3:0] F_REMU   = 4'd13;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Captured iterative op: the multiplicand/divisor and which result to return.
    typedef struct packed {
        logic [3:0]      func;
        logic [XLEN-1:0] b;
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   res_q;

    logic [XLEN-1:0]   a_mux, b_mux, sc_res, iter_res;
    logic [SW-1:0]     shamt;
    logic              is_iter, accept;
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_d;
    logic [XLEN-1:0]   div_rem;
    logic              div_ge, op_is_div;

    assign accept  = alu.in_valid & (state_q == IDLE) & ~alu.flush;
    assign is_iter = (alu.func >= F_MUL) && (alu.func <= F_REMU);
    assign shamt   = b_mux[SW-1:0];

    // Operand selection from the raw sources.
    always_comb begin
        a_mux = '0;
        b_mux = '0;
        case (alu.a_sel)
            2'd1:    a_mux = alu.src1;
            2'd2:    a_mux = alu.pc_out;
            default: a_mux = '0;
        endcase
        case (alu.b_sel)
            2'd1:    b_mux = alu.src2;
            2'd2:    b_mux = alu.imm;
            2'd3:    b_mux = XLEN'(3'd4);
            default: b_mux = '0;
        endcase
    end

    // Single-cycle result, computed from the selected operands at accept.
    always_comb begin
        sc_res = '0;
        case (alu.func)
            F_ADD:    sc_res = a_mux + b_mux;
            F_SUB:    sc_res = a_mux - b_mux;
            F_EQ:     sc_res = {{(XLEN-1){1'b0}}, a_mux == b_mux};
            F_NE:     sc_res = {{(XLEN-1){1'b0}}, a_mux != b_mux};
            F_LESS_U: sc_res = {{(XLEN-1){1'b0}}, a_mux < b_mux};
            F_LESS_S: sc_res = {{(XLEN-1){1'b0}}, $signed(a_mux) < $signed(b_mux)};
            F_SLL:    sc_res = a_mux << shamt;
            F_SRL:    sc_res = a_mux >> shamt;
            F_SRA:    sc_res = $signed(a_mux) >>> shamt;
            default:  sc_res = '0;
        endcase
    end

    // One iteration step. The accumulator holds {hi, lo}: for multiply lo is the
    // remaining multiplier and hi the partial product; for divide hi is the partial
    // remainder and lo shifts dividend bits out while quotient bits shift in.
    // A zero divisor naturally yields an all-ones quotient and remainder = a.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q.b} : '0);
        mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
        div_diff  = acc_q[2*XLEN-1:XLEN-1] - {1'b0, op_q.b};
        div_ge    = ~div_diff[XLEN];
        div_rem   = div_ge ? div_diff[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1];
        div_nxt   = {div_rem, acc_q[XLEN-2:0], div_ge};
        op_is_div = (op_q.func == F_DIVU) || (op_q.func == F_REMU);
        acc_d     = op_is_div ? div_nxt : mul_nxt;
        iter_res  = '0;
        case (op_q.func)
            F_MUL:   iter_res = mul_nxt[XLEN-1:0];
            F_MULHU: iter_res = mul_nxt[2*XLEN-1:XLEN];
            F_DIVU:  iter_res = div_nxt[XLEN-1:0];
            F_REMU:  iter_res = div_nxt[2*XLEN-1:XLEN];
            default: iter_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = is_iter ? BUSY : DONE;
            BUSY:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    if (alu.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (alu.flush) state_d = IDLE;
    end

    // Datapath: capture at accept, iterate in BUSY, load the final result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q  <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            res_q <= '0;
        end else if (accept) begin
            op_q  <= '{func: alu.func, b: b_mux};
            cnt_q <= CW'(XLEN);
            acc_q <= {{XLEN{1'b0}}, a_mux};
            if (!is_iter) res_q <= sc_res;
        end else if ((state_q == BUSY) && !alu.flush) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) res_q <= iter_res;
        end
    end

    assign alu.in_ready   = (state_q == IDLE);
    assign alu.busy       = (state_q == BUSY);
    assign alu.out_valid  = (state_q == DONE);
    assign alu.alu_result = res_q;
endmodule

// File: doc/exu_alu_mc.md
# exu_alu_mc

Parametrised multi-cycle successor to the execute-stage ALU: selects operands (zero/src1/pc, zero/src2/imm/4), runs a single-cycle integer op or an iterative multiply/divide, and returns a registered result over a valid/ready handshake. It sits in the EXU between decode (IDU) and writeback/LSU. It lets the core move from single-cycle to handshaked multi-cycle execution and adds shifts, signed compare, MUL/MULHU and DIVU/REMU.

## Interface
- XLEN, 32, datapath width; power of two, 8..64; internal counter width is clog2(XLEN)+1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- in_valid  in  1  request present
- in_ready  out  1  block can accept; high only in IDLE
- a_sel  in  2  0:zero 1:src1 2:pc 3:zero
- b_sel  in  2  0:zero 1:src2 2:imm 3:constant 4
- func  in  4  0 NO_FUNC, 1 ADD, 2 SUB, 3 EQ, 4 NE, 5 LESS_U, 6 LESS_S, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 MULHU, 12 DIVU, 13 REMU, 14-15 NO_FUNC
- src1, src2, pc_out, imm  in  XLEN each  operand sources
- flush  in  1  synchronous abort of the in-flight op
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- alu_result  out  XLEN  result, stable while out_valid=1
- busy  out  1  high in BUSY

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE, out_valid=0, alu_result=0, busy=0, in_ready=1.
- Accept: in_valid & in_ready. Operands a, b are selected and captured at accept; later input changes are ignored.
- Single-cycle funcs (0-9, 14, 15): result computed at accept and registered; IDLE→DONE.
- ADD/SUB: mod 2^XLEN. EQ/NE/LESS_U/LESS_S: result is 0 or 1, zero-extended.
- Shift amount is b[clog2(XLEN)-1:0]; SRA replicates a[XLEN-1].
- NO_FUNC result is 0.
- MUL, MULHU: shift-add over XLEN iterations (one multiplier bit per cycle) with a 2·XLEN accumulator. MUL returns the low half, MULHU the high half (unsigned).
- DIVU, REMU: restoring division, one quotient bit per cycle, XLEN iterations.
- Divide by zero (b=0): DIVU returns all ones and REMU returns a, using the normal XLEN-cycle latency.
- Iterative funcs go IDLE→BUSY; the counter loads XLEN and decrements each cycle; at 1, BUSY→DONE.
- DONE: out_valid=1 and alu_result held. On out_ready → IDLE.
- flush: any state → IDLE next edge. out_valid drops, and a pending result is discarded without being transferred even if out_ready=1 in the same cycle. flush has priority over accept: in_valid & flush in IDLE → no accept.
- Async reset mid-BUSY/DONE: immediate return to reset values; no result is produced.

## Timing
- Accept at edge T (cycle T). Single-cycle op: out_valid=1 from T+1.
- Iterative op: busy=1 for cycles T+1..T+XLEN; out_valid=1 from T+XLEN+1.
- out_ready sampled only while out_valid=1. The transfer completes at that edge and out_valid=0 next cycle.
- in_ready rises in the cycle after the transfer; there is no same-cycle accept during DONE. Minimum initiation interval is 2 cycles.
- Backpressure: out_valid and alu_result are held for any number of cycles with out_ready=0.
- in_ready is a pure function of state (no combinational path from in_valid). out_valid and alu_result are registered.

## Test plan
- Reset/defaults: hold rst=0 for 3 cycles → out_valid=0, alu_result=0, in_ready=1, busy=0. Release, then issue a_sel=2 (pc 0x80000000), b_sel=3, ADD → 0x80000004 at T+1.
- Single-cycle set: SUB 5-7 → 0xFFFFFFFE. LESS_S(-1,1)=1. LESS_U(-1,1)=0. SRA(0x80000000, 4)=0xF8000000. SLL with b=33 → shift 1. NE(3,3)=0. Each result arrives at T+1.
- Iterative (XLEN=32): MULHU(0xFFFFFFFF, 0xFFFFFFFF)=0xFFFFFFFE. MUL(0x12345678, 0x10)=0x23456780. DIVU(100,7)=14. REMU(100,7)=2. Each result arrives at T+33 with busy high for exactly 32 cycles.
- Divide by zero: DIVU(0x1234, 0) → 0xFFFFFFFF. REMU(0x1234, 0) → 0x1234. Latency 33.
- Backpressure/flush: hold out_ready=0 for 10 cycles → result stable, in_ready=0. Separately, flush at T+5 of a DIVU → IDLE next cycle, with no out_valid afterwards. Then a new ADD is accepted and returns correctly.
- Parametrisation: rerun the iterative and shift tests at XLEN=8 and XLEN=64 against a reference model with random operands; iterative latency must equal XLEN+1.
